// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Single-word SPI master with run-time CPOL/CPHA, a programmable clock
//   divider and a decoded active-low chip-select bus. Every configuration and
//   data input is latched when a transfer starts.
//   Optional feature: define SPI_MASTER_LSB_FIRST_EN to add the lsb_first
//   input. When lsb_first is 1, the transfer shifts LSB first. Without the
//   macro, transfers are always MSB first.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   SPI_start  in   transfer request, sampled while idle
//   cpol       in   SPI clock polarity
//   cpha       in   SPI clock phase
//   clk_div    in   [DIV_W]  half-period minus one, in clk cycles
//   cs_sel     in   [CS_W]   target slave index
//   data_in    in   [DATA_W] transmit word
//   lsb_first  in   LSB-first select (only with SPI_MASTER_LSB_FIRST_EN)
//   SPI_MISO   in   serial data from slave
//   SPI_CLK    out  serial clock
//   SPI_MOSI   out  serial data to slave
//   SPI_CS_N   out  [NUM_CS] active-low chip selects
//   busy       out  transfer in progress
//   done       out  one-cycle completion pulse
//   data_out   out  [DATA_W] last received word
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CS = 4,
    parameter int unsigned DIV_W  = 8,
    localparam int unsigned CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SPI_start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] data_in,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic              SPI_MISO,
    output logic              SPI_CLK,
    output logic              SPI_MOSI,
    output logic [NUM_CS-1:0] SPI_CS_N,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out
);

    localparam int unsigned EDGE_W = $clog2(2 * DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    r_cnt;
    logic [EDGE_W-1:0]   r_edges;
    logic                r_cpol;
    logic                r_cpha;
    logic                r_lsb;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic                r_sclk;
    logic                r_mosi;
    logic [NUM_CS-1:0]   r_cs_n;
    logic                r_busy;
    logic                r_done;
    logic [DATA_W-1:0]   r_data_out;

    logic                w_lsb_in;
    logic                w_half_end;
    logic                w_last_edge;
    logic                w_sample;
    logic [NUM_CS-1:0]   w_cs_dec;
    logic                w_in_bit;
    logic [DATA_W-1:0]  w_in_shift;
    logic                w_tx_bit;
    logic [DATA_W-1:0]  w_tx_shift;
    logic [DATA_W-1:0]  w_rx_shift;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign w_lsb_in = lsb_first;
`else
    assign w_lsb_in = 1'b0;
`endif

    assign w_half_end  = (r_cnt == r_div);
    assign w_last_edge = (r_edges == EDGE_W'(2 * DATA_W - 1));
    // Even edge count means the next edge is a leading edge.
    // Mode 0/2 sample on leading edges. Mode 1/3 sample on trailing edges.
    assign w_sample    = (~r_edges[0]) ^ r_cpha;

    // Chip-select decode. An index without a matching line leaves all high.
    always_comb begin
        w_cs_dec = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (32'(cs_sel) == i) begin
                w_cs_dec[i] = 1'b0;
            end
        end
    end

    // Shift helpers for first-bit-at-start, later MOSI bits and MISO capture.
    always_comb begin
        w_in_bit   = w_lsb_in ? data_in[0] : data_in[DATA_W-1];
        w_in_shift = w_lsb_in ? {1'b0, data_in[DATA_W-1:1]} : {data_in[DATA_W-2:0], 1'b0};
        w_tx_bit   = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
        w_tx_shift = r_lsb ? {1'b0, r_tx[DATA_W-1:1]} : {r_tx[DATA_W-2:0], 1'b0};
        w_rx_shift = r_lsb ? {SPI_MISO, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], SPI_MISO};
    end

    // Transfer FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_div      <= '0;
            r_cnt      <= '0;
            r_edges    <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= '1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (SPI_start) begin
                        r_state <= LEAD;
                        r_busy  <= 1'b1;
                        r_cpol  <= cpol;
                        r_cpha  <= cpha;
                        r_div   <= clk_div;
                        r_lsb   <= w_lsb_in;
                        r_cnt   <= '0;
                        r_edges <= '0;
                        r_rx    <= '0;
                        r_cs_n  <= w_cs_dec;
                        r_sclk  <= cpol;
                        // cpha=0 presents the first bit before the first edge.
                        if (cpha) begin
                            r_tx   <= data_in;
                            r_mosi <= 1'b0;
                        end else begin
                            r_tx   <= w_in_shift;
                            r_mosi <= w_in_bit;
                        end
                    end
                end
                LEAD: begin
                    if (w_half_end) begin
                        r_cnt   <= '0;
                        r_state <= XFER;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                XFER: begin
                    if (w_half_end) begin
                        r_cnt   <= '0;
                        r_sclk  <= ~r_sclk;
                        r_edges <= r_edges + EDGE_W'(1);
                        if (w_sample) begin
                            r_rx <= w_rx_shift;
                        end else begin
                            r_mosi <= w_tx_bit;
                            r_tx   <= w_tx_shift;
                        end
                        if (w_last_edge) begin
                            r_state <= TRAIL;
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                TRAIL: begin
                    if (w_half_end) begin
                        r_state    <= IDLE;
                        r_cnt      <= '0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_cs_n     <= '1;
                        r_mosi     <= 1'b0;
                        r_sclk     <= r_cpol;
                        r_data_out <= r_rx;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign SPI_CLK  = r_sclk;
    assign SPI_MOSI = r_mosi;
    assign SPI_CS_N = r_cs_n;
    assign busy     = r_busy;
    assign done     = r_done;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Directed, table-driven bench for spi_master (DATA_W=8, NUM_CS=4, DIV_W=8).
//   A small slave model either loops MOSI back to MISO or shifts out a fixed
//   word in mode 0.
// -----------------------------------------------------------------------------
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       SPI_start;
    logic       cpol;
    logic       cpha;
    logic [7:0] clk_div;
    logic [1:0] cs_sel;
    logic [7:0] data_in;
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic       lsb_first;
`endif
    logic       SPI_MISO;
    logic       SPI_CLK;
    logic       SPI_MOSI;
    logic [3:0] SPI_CS_N;
    logic       busy;
    logic       done;
    logic [7:0] data_out;

    int n_pass  = 0;
    int n_total = 0;

    // Slave model: loopback, or a mode-0 shifter that advances on falling SCLK.
    logic       loopback;
    logic [7:0] slv_word;
    logic [3:0] slv_cnt = 4'd0;
    logic [7:0] slv_sh;
    logic       cs_idle;

    assign cs_idle  = &SPI_CS_N;
    assign slv_sh   = slv_word << slv_cnt;
    assign SPI_MISO = loopback ? SPI_MOSI : slv_sh[7];

    always @(negedge SPI_CLK or posedge cs_idle) begin
        if (cs_idle)
            slv_cnt <= 4'd0;
        else if (slv_cnt != 4'd15)
            slv_cnt <= slv_cnt + 4'd1;
    end

    always #5 clk = ~clk;

    spi_master #(
        .DATA_W (8),
        .NUM_CS (4),
        .DIV_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SPI_start (SPI_start),
        .cpol      (cpol),
        .cpha      (cpha),
        .clk_div   (clk_div),
        .cs_sel    (cs_sel),
        .data_in   (data_in),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .SPI_MISO  (SPI_MISO),
        .SPI_CLK   (SPI_CLK),
        .SPI_MOSI  (SPI_MOSI),
        .SPI_CS_N  (SPI_CS_N),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out)
    );

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [7:0] div;
        logic [1:0] cs;
        logic [7:0] din;
        logic       lb;
        logic [7:0] slv;
        logic [7:0] exp_dout;
        logic [7:0] exp_mosi;
        logic [3:0] exp_cs;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // Run one transfer and check it from the pins: timing, edges, MOSI, CS, result.
    task automatic run_xfer(input vec_t v, input string tag);
        int         cyc;
        int         edges;
        int         dn;
        int         exp_busy;
        logic       prev;
        logic [7:0] mcap;
        logic [3:0] csacc;
        @(negedge clk);
        cpol      = v.cpol;
        cpha      = v.cpha;
        clk_div   = v.div;
        cs_sel    = v.cs;
        data_in   = v.din;
        loopback  = v.lb;
        slv_word  = v.slv;
        SPI_start = 1'b1;
        @(negedge clk);
        SPI_start = 1'b0;
        cyc   = 0;
        edges = 0;
        dn    = 0;
        prev  = SPI_CLK;
        mcap  = 8'h00;
        csacc = 4'h0;
        while (busy && cyc < 1000) begin
            cyc++;
            csacc = csacc | ~SPI_CS_N;
            @(negedge clk);
            if (SPI_CLK !== prev) begin
                if (((edges % 2) == 0) != v.cpha)
                    mcap = {mcap[6:0], SPI_MOSI};
                edges++;
            end
            prev = SPI_CLK;
            if (done) dn++;
        end
        chk({tag, "_timeout"}, 32'(cyc < 1000), 32'd1);
        chk({tag, "_data_out"}, 32'(data_out), 32'(v.exp_dout));
        chk({tag, "_cs_idle"}, 32'(SPI_CS_N), 32'hF);
        chk({tag, "_mosi_idle"}, 32'(SPI_MOSI), 32'd0);
        repeat (2) begin
            @(negedge clk);
            if (done) dn++;
        end
        exp_busy = 18 * (int'(v.div) + 1);
        chk_rng({tag, "_busy_cycles"}, cyc, exp_busy - 1, exp_busy + 1);
        chk({tag, "_edges"}, 32'(edges), 32'd16);
        chk({tag, "_mosi_bits"}, 32'(mcap), 32'(v.exp_mosi));
        chk({tag, "_cs_seen"}, 32'(csacc), 32'(v.exp_cs));
        chk({tag, "_done_pulses"}, 32'(dn), 32'd1);
        chk({tag, "_sclk_idle"}, 32'(SPI_CLK), 32'(v.cpol));
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int   cyc;
        int   dn;
        vec_t v;

        // cpol cpha div cs din lb slv exp_dout exp_mosi exp_cs
        vecs[0] = '{1'b0, 1'b0, 8'd0, 2'd1, 8'hA5, 1'b0, 8'h3C, 8'h3C, 8'hA5, 4'b0010};
        vecs[1] = '{1'b0, 1'b1, 8'd0, 2'd0, 8'h81, 1'b1, 8'h00, 8'h81, 8'h81, 4'b0001};
        vecs[2] = '{1'b1, 1'b0, 8'd0, 2'd2, 8'h81, 1'b1, 8'h00, 8'h81, 8'h81, 4'b0100};
        vecs[3] = '{1'b1, 1'b1, 8'd0, 2'd3, 8'h81, 1'b1, 8'h00, 8'h81, 8'h81, 4'b1000};
        vecs[4] = '{1'b0, 1'b0, 8'd3, 2'd0, 8'hC3, 1'b1, 8'h00, 8'hC3, 8'hC3, 4'b0001};
        vecs[5] = '{1'b1, 1'b1, 8'd1, 2'd1, 8'h5A, 1'b1, 8'h00, 8'h5A, 8'h5A, 4'b0010};

        rst       = 1'b1;
        SPI_start = 1'b0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        clk_div   = 8'd0;
        cs_sel    = 2'd0;
        data_in   = 8'h00;
        loopback  = 1'b1;
        slv_word  = 8'h00;
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(SPI_CLK), 32'd0);
        chk("rst_mosi", 32'(SPI_MOSI), 32'd0);
        chk("rst_cs", 32'(SPI_CS_N), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_xfer(vecs[i], $sformatf("vec%0d", i));

        // Start requests during a transfer are ignored; a start on the done cycle is taken.
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; cs_sel = 2'd2;
        data_in = 8'h96; loopback = 1'b1; SPI_start = 1'b1;
        @(negedge clk);
        SPI_start = 1'b0;
        repeat (5) @(negedge clk);
        data_in = 8'hFF; cpol = 1'b1; cpha = 1'b1; SPI_start = 1'b1;
        @(negedge clk);
        SPI_start = 1'b0; data_in = 8'h96; cpol = 1'b0; cpha = 1'b0;
        wait_done(cyc);
        chk("b2b_first_done", 32'(done), 32'd1);
        chk("b2b_first_data", 32'(data_out), 32'h96);
        chk("b2b_cs_gap", 32'(SPI_CS_N), 32'hF);
        chk("b2b_sclk", 32'(SPI_CLK), 32'd0);
        chk("b2b_busy_low", 32'(busy), 32'd0);
        data_in = 8'h55; SPI_start = 1'b1;
        @(negedge clk);
        SPI_start = 1'b0;
        chk("b2b_second_busy", 32'(busy), 32'd1);
        chk("b2b_second_cs", 32'(SPI_CS_N), 32'b1011);
        wait_done(cyc);
        chk("b2b_second_done", 32'(done), 32'd1);
        chk("b2b_second_data", 32'(data_out), 32'h55);

        // Reset after three bits aborts the transfer with no done pulse.
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; cs_sel = 2'd0;
        data_in = 8'hA5; loopback = 1'b1; SPI_start = 1'b1;
        @(negedge clk);
        SPI_start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_midway_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_cs", 32'(SPI_CS_N), 32'hF);
        chk("abort_sclk", 32'(SPI_CLK), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mosi", 32'(SPI_MOSI), 32'd0);
        chk("abort_data_out", 32'(data_out), 32'd0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        v = '{1'b0, 1'b0, 8'd0, 2'd0, 8'hF0, 1'b1, 8'h00, 8'hF0, 8'hF0, 4'b0001};
        run_xfer(v, "post_rst");

`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb_first = 1'b1;
        v = '{1'b0, 1'b0, 8'd0, 2'd0, 8'h01, 1'b1, 8'h00, 8'h01, 8'h80, 4'b0001};
        run_xfer(v, "lsb_first");
        lsb_first = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
